// File: rtl/data_mem_banked_pkg.sv
// Shared definitions for the banked data memory: access-size opcodes and FSM states.
package data_mem_banked_pkg;

    localparam int DM_OP_BIT = 3;

    localparam logic [DM_OP_BIT-1:0] DM_OP_WD = 3'd0;
    localparam logic [DM_OP_BIT-1:0] DM_OP_UB = 3'd1;
    localparam logic [DM_OP_BIT-1:0] DM_OP_SB = 3'd2;
    localparam logic [DM_OP_BIT-1:0] DM_OP_UH = 3'd3;
    localparam logic [DM_OP_BIT-1:0] DM_OP_SH = 3'd4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_lane_ram.sv
// One byte lane of the data memory: a synchronous read/write port plus an
// independent registered debug read port that is forced to zero when disabled.
module dm_lane_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    input  logic              dbg_en,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Read-before-write: a read in the same cycle as a write sees the old byte.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

    always_ff @(posedge clk) begin
        if (rst || !dbg_en) begin
            dbg_rdata <= 8'h00;
        end else begin
            dbg_rdata <= mem[dbg_addr];
        end
    end

endmodule

// File: rtl/data_mem_banked.sv
// Byte-lane-banked synchronous data memory with post-reset clear sweep,
// sized/signed loads, misalignment detection and a valid/ready request port.
module data_mem_banked
    import data_mem_banked_pkg::*;
#(
    parameter int          ADDR_BIT  = 12,
    parameter int          LANES     = 4,
    parameter logic [7:0]  CLEAR_VAL = 8'h00,
    localparam int         LB        = $clog2(LANES),
    localparam int         DATA_W    = 8 * LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [DM_OP_BIT-1:0]   req_op,
    input  logic [ADDR_BIT-1:0]    req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    input  logic [ADDR_BIT-LB-1:0] dbg_addr,
    output logic [DATA_W-1:0]      dbg_data,
    output logic                   init_done
);

    localparam int WA = ADDR_BIT - LB;

    dm_state_e             state;
    logic [WA-1:0]         clr_cnt;
    logic                  accept;
    logic                  store_en;
    logic                  op_ok;
    logic [LANES-1:0]      be;
    logic [DATA_W-1:0]     wdata_rep;
    logic [LB-1:0]         offset;
    logic [WA-1:0]         ram_addr;
    logic [LANES-1:0]      lane_we;
    logic [DATA_W-1:0]     rd_word;
    logic                  load_q;
    logic [DM_OP_BIT-1:0]  op_q;
    logic [LB-1:0]         off_q;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign offset   = req_addr[LB-1:0];
    assign accept   = req_valid && req_ready && !rst;
    assign store_en = accept && req_we && op_ok;
    assign ram_addr = (state == ST_INIT) ? clr_cnt : req_addr[ADDR_BIT-1:LB];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Store data is replicated across the word so every enabled lane simply
    // picks up its own byte position, whatever the access size.
    always_comb begin
        op_ok     = 1'b0;
        be        = '0;
        wdata_rep = req_wdata;
        case (req_op)
            DM_OP_WD: begin
                op_ok = (offset == '0);
                be    = '1;
            end
            DM_OP_UB, DM_OP_SB: begin
                op_ok     = 1'b1;
                be        = LANES'(1) << offset;
                wdata_rep = {LANES{req_wdata[7:0]}};
            end
            DM_OP_UH, DM_OP_SH: begin
                op_ok     = !offset[0];
                be        = LANES'(3) << (offset & ~LB'(1));
                wdata_rep = {(LANES/2){req_wdata[15:0]}};
            end
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_we[i] = !rst && ((state == ST_INIT) || (store_en && be[i]));

        dm_lane_ram #(
            .ADDR_W (WA)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .we        (lane_we[i]),
            .addr      (ram_addr),
            .wdata     ((state == ST_INIT) ? CLEAR_VAL : wdata_rep[8*i +: 8]),
            .rdata     (rd_word[8*i +: 8]),
            .dbg_en    (state == ST_RUN),
            .dbg_addr  (dbg_addr),
            .dbg_rdata (dbg_data[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_q    <= 1'b0;
            op_q      <= DM_OP_WD;
            off_q     <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && !op_ok;
            load_q    <= accept && !req_we && op_ok;
            op_q      <= req_op;
            off_q     <= offset;
        end
    end

    // Lane data arrives from the RAMs one cycle after accept; extension uses
    // the op and offset captured alongside it.
    always_comb begin
        byte_sel  = rd_word[8*int'(off_q) +: 8];
        half_sel  = rd_word[16*(int'(off_q)/2) +: 16];
        rsp_rdata = '0;
        if (load_q) begin
            case (op_q)
                DM_OP_WD: rsp_rdata = rd_word;
                DM_OP_UB: rsp_rdata = {{(DATA_W-8){1'b0}}, byte_sel};
                DM_OP_SB: rsp_rdata = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
                DM_OP_UH: rsp_rdata = {{(DATA_W-16){1'b0}}, half_sel};
                DM_OP_SH: rsp_rdata = {{(DATA_W-16){half_sel[15]}}, half_sel};
                default:  rsp_rdata = '0;
            endcase
        end
    end

endmodule
